// File: rtl/f1_pkg.sv
// ============================================================================
// Module   : f1_pkg
// Brief    : Shared types and constants for the F1 start-light enable source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package f1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEQ   = 2'd1,
        DELAY = 2'd2
    } state_t;

    localparam int LFSR_SEED   = 1;
    // Feedback taps for x^7 + x^3 + 1 (bit indices of the 7-bit register)
    localparam int LFSR_TAP_HI = 6;
    localparam int LFSR_TAP_LO = 2;

endpackage

`default_nettype wire

// File: rtl/f1_lfsr.sv
// ============================================================================
// Module   : f1_lfsr
// Brief    : Free-running Fibonacci LFSR, reset to the seed; never reaches 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f1_lfsr
    import f1_pkg::*;
#(
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= LFSR_W'(LFSR_SEED);
        end else begin
            r_q <= {r_q[LFSR_W-2:0], r_q[LFSR_TAP_HI] ^ r_q[LFSR_TAP_LO]};
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/f1_en_gen.sv
// ============================================================================
// Module   : f1_en_gen
// Brief    : Enable source for the start-light sequencer: periodic fill pulses,
//            then one lights-out pulse after a pseudo-random delay.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module f1_en_gen
    import f1_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LFSR_W = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  n,
    input  logic              trigger,
    input  logic              cmd_seq,
    input  logic              cmd_delay,
    output logic              en,
    output logic              busy,
    output logic              delay_active,
    output logic [LFSR_W-1:0] delay_val
);

    state_t            r_state;
    logic [WIDTH-1:0]  r_cnt;
    logic [LFSR_W-1:0] r_dcnt;
    logic [LFSR_W-1:0] r_delay_val;
    logic [LFSR_W-1:0] w_lfsr;
    logic              w_tick;
    logic              w_seq_en;
    logic              w_delay_en;

    f1_lfsr #(
        .LFSR_W (LFSR_W)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .q   (w_lfsr)
    );

    assign w_tick     = ((r_state == SEQ) || (r_state == DELAY)) && (r_cnt == '0);
    // cmd_delay wins over a coincident tick: the capture cycle never advances
    assign w_seq_en   = (r_state == SEQ) && !cmd_delay && cmd_seq && w_tick;
    assign w_delay_en = (r_state == DELAY) && w_tick && (r_dcnt == LFSR_W'(1));

    assign en           = !rst && (w_seq_en || w_delay_en);
    assign busy         = (r_state != IDLE);
    assign delay_active = (r_state == DELAY);
    assign delay_val    = r_delay_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dcnt      <= '0;
            r_delay_val <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trigger && cmd_seq) begin
                        r_state <= SEQ;
                        r_cnt   <= n;
                    end
                end
                SEQ: begin
                    if (cmd_delay) begin
                        r_state     <= DELAY;
                        r_cnt       <= n;
                        r_dcnt      <= w_lfsr;
                        r_delay_val <= w_lfsr;
                    end else if (w_tick) begin
                        r_cnt <= n;
                    end else begin
                        r_cnt <= r_cnt - WIDTH'(1);
                    end
                end
                DELAY: begin
                    if (w_tick) begin
                        r_cnt  <= n;
                        r_dcnt <= r_dcnt - LFSR_W'(1);
                        if (r_dcnt == LFSR_W'(1)) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - WIDTH'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_f1_en_gen.sv
// ============================================================================
// Module   : tb_f1_en_gen
// Brief    : Directed self-checking bench for f1_en_gen.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_f1_en_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] n = 16'd0;
    logic        trigger = 1'b0;
    logic        cmd_seq = 1'b0;
    logic        cmd_delay = 1'b0;
    logic        en;
    logic        busy;
    logic        delay_active;
    logic [6:0]  delay_val;
    logic [6:0]  m_lfsr;

    int checks   = 0;
    int failures = 0;

    f1_en_gen #(
        .WIDTH  (16),
        .LFSR_W (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .n            (n),
        .trigger      (trigger),
        .cmd_seq      (cmd_seq),
        .cmd_delay    (cmd_delay),
        .en           (en),
        .busy         (busy),
        .delay_active (delay_active),
        .delay_val    (delay_val)
    );

    always #5 clk = ~clk;

    // Reference x^7+x^3+1 sequence, used to predict captured delays
    always @(posedge clk) begin
        if (rst) m_lfsr <= 7'd1;
        else     m_lfsr <= {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[2]};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at "sample 0": 1 time unit after the last reset edge
    task automatic do_reset();
        rst = 1'b1; trigger = 1'b0; cmd_seq = 1'b0; cmd_delay = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [6:0] exp_q [5];
        exp_q = '{7'h01, 7'h02, 7'h04, 7'h09, 7'h12};
        do_reset();
        checks++;
        if (delay_val !== 7'd0 || delay_active !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs delay_val=%0d delay_active=%0b required 0/0", delay_val, delay_active);
        end
        for (int i = 0; i < 5; i++) begin
            // trigger without cmd_seq must be ignored
            if (i >= 2) trigger = 1'b1;
            checks++;
            if (dut.u_lfsr.q !== exp_q[i]) begin
                failures++;
                $display("FAIL reset_lfsr[%0d] got=%h required=%h", i, dut.u_lfsr.q, exp_q[i]);
            end
            checks++;
            if (en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle[%0d] en=%0b busy=%0b required 0/0", i, en, busy);
            end
            step();
        end
        trigger = 1'b0;
    endtask

    task automatic test_seq_period();
        n = 16'd3;
        do_reset();
        cmd_seq = 1'b1;
        for (int k = 0; k < 9; k++) step();
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL seq_busy got=%0b required=1", busy);
        end
        // Sample k shows the en consumed at edge k+1; pulses land on edges 14,18,22
        for (int k = 10; k <= 22; k++) begin
            logic exp_en;
            exp_en = ((k + 1) >= 14) && (((k + 1 - 14) % 4) == 0);
            checks++;
            if (en !== exp_en) begin
                failures++;
                $display("FAIL seq_en@edge%0d got=%0b required=%0b", k + 1, en, exp_en);
            end
            step();
        end
        cmd_seq = 1'b0;
    endtask

    task automatic test_closed_loop();
        int   sq, pulses, entry_k, exp_dv, m_prev;
        int   pk [9];
        logic got_en, prev_da;
        n = 16'd1;
        do_reset();
        sq = 0; pulses = 0; entry_k = -1; exp_dv = -1; m_prev = 1;
        got_en = 1'b0; prev_da = 1'b0;
        trigger = 1'b1;
        for (int k = 0; k < 400 && pulses < 9; k++) begin
            if (k > 0) step();
            if (got_en) sq = (sq == 8) ? 0 : sq + 1;
            cmd_seq   = (sq < 8);
            cmd_delay = (sq == 8);
            if (k == 1) trigger = 1'b0;
            #1;
            got_en = en;
            if (delay_active && !prev_da) begin
                entry_k = k;
                exp_dv  = m_prev;
            end
            prev_da = delay_active;
            if (got_en) begin
                pk[pulses] = k;
                pulses++;
            end
            m_prev = int'(m_lfsr);
        end
        checks++;
        if (pulses != 9 || entry_k < 0) begin
            failures++;
            $display("FAIL loop_timeout pulses=%0d entry=%0d required 9 pulses and a DELAY entry", pulses, entry_k);
        end else begin
            checks++;
            if (pk[0] != 2) begin
                failures++;
                $display("FAIL loop_first_en sample=%0d required=2", pk[0]);
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (pk[i] - pk[i-1] != 2) begin
                    failures++;
                    $display("FAIL loop_spacing[%0d] got=%0d required=2", i, pk[i] - pk[i-1]);
                end
            end
            checks++;
            if (!(entry_k > pk[7] && entry_k < pk[8])) begin
                failures++;
                $display("FAIL loop_order entry=%0d fill_last=%0d final=%0d", entry_k, pk[7], pk[8]);
            end
            checks++;
            if (int'(delay_val) != exp_dv || delay_val == 7'd0) begin
                failures++;
                $display("FAIL loop_delay_val got=%0d required=%0d (nonzero)", delay_val, exp_dv);
            end
            checks++;
            if ((pk[8] + 1 - entry_k) != int'(delay_val) * 2) begin
                failures++;
                $display("FAIL loop_delay_len got=%0d required=%0d", pk[8] + 1 - entry_k, int'(delay_val) * 2);
            end
        end
        // Sequencer wraps to S0 (cmd_seq=1) but no trigger: no en in IDLE
        for (int i = 0; i < 5; i++) begin
            step();
            if (got_en) begin
                sq = (sq == 8) ? 0 : sq + 1;
                got_en = 1'b0;
            end
            cmd_seq   = (sq < 8);
            cmd_delay = (sq == 8);
            #1;
            checks++;
            if (en !== 1'b0 || busy !== 1'b0 || delay_active !== 1'b0) begin
                failures++;
                $display("FAIL loop_idle[%0d] en=%0b busy=%0b delay_active=%0b required 0/0/0", i, en, busy, delay_active);
            end
        end
        cmd_seq = 1'b0; cmd_delay = 1'b0;
    endtask

    task automatic test_n0_capture();
        logic found;
        n = 16'd0;
        do_reset();
        cmd_seq = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        // Wait for the sequence to wrap back to the seed so the capture sees 01
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_lfsr == 7'd1) found = 1'b1;
            else step();
        end
        checks++;
        if (!found || busy !== 1'b1) begin
            failures++;
            $display("FAIL n0_setup found=%0b busy=%0b required 1/1", found, busy);
        end
        cmd_delay = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0) begin
            failures++;
            $display("FAIL n0_capture_en got=%0b required=0", en);
        end
        step();
        cmd_delay = 1'b0; cmd_seq = 1'b0;
        #1;
        checks++;
        if (delay_active !== 1'b1 || delay_val !== 7'd1 || en !== 1'b1) begin
            failures++;
            $display("FAIL n0_delay delay_active=%0b delay_val=%0d en=%0b required 1/1/1", delay_active, delay_val, en);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL n0_after[%0d] en=%0b busy=%0b required 0/0", i, en, busy);
            end
        end
    endtask

    task automatic test_rst_mid_delay();
        logic found;
        n = 16'd5;
        do_reset();
        cmd_seq = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            if (m_lfsr > 7'd40) found = 1'b1;
            else step();
        end
        cmd_delay = 1'b1;
        step();
        cmd_delay = 1'b0; cmd_seq = 1'b0;
        #1;
        checks++;
        if (!found || delay_active !== 1'b1 || delay_val <= 7'd40) begin
            failures++;
            $display("FAIL rst_setup found=%0b delay_active=%0b delay_val=%0d required 1/1/>40", found, delay_active, delay_val);
        end
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            if (dut.r_dcnt == 7'd40) found = 1'b1;
            else step();
        end
        checks++;
        if (!found || delay_active !== 1'b1) begin
            failures++;
            $display("FAIL rst_wait_dcnt found=%0b delay_active=%0b required 1/1", found, delay_active);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0) begin
            failures++;
            $display("FAIL rst_cycle_en got=%0b required=0", en);
        end
        step();
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || delay_active !== 1'b0 || en !== 1'b0 || dut.u_lfsr.q !== 7'h01) begin
            failures++;
            $display("FAIL rst_state busy=%0b delay_active=%0b en=%0b lfsr=%h required 0/0/0/01", busy, delay_active, en, dut.u_lfsr.q);
        end
        cmd_seq = 1'b1;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart_busy got=%0b required=1", busy);
        end
        for (int i = 1; i <= 5; i++) begin
            step();
            checks++;
            if (en !== (i == 5)) begin
                failures++;
                $display("FAIL rst_restart_en[%0d] got=%0b required=%0b", i, en, (i == 5));
            end
        end
        cmd_seq = 1'b0;
    endtask

    task automatic test_back_to_back();
        n = 16'd3;
        do_reset();
        cmd_seq = 1'b1;
        trigger = 1'b1;
        // Trigger stays high throughout; period 4 finishes, then period 8
        for (int k = 1; k <= 25; k++) begin
            logic exp_en;
            step();
            if (k == 6) n = 16'd7;
            #1;
            exp_en = (k == 4) || (k == 8) || (k == 16) || (k == 24);
            checks++;
            if (en !== exp_en || busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_en[%0d] en=%0b busy=%0b required %0b/1", k, en, busy, exp_en);
            end
        end
        trigger = 1'b0; cmd_seq = 1'b0;
    endtask

    initial begin
        test_reset();
        test_seq_period();
        test_closed_loop();
        test_n0_capture();
        test_rst_mid_delay();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
